// File: rtl/fifo_rd_cntrl.sv
// Read-side controller of an asynchronous FIFO: Gray/binary read pointer, registered output stage.
// Optional occupancy output LEVEL is built when FIFO_RD_LEVEL_EN is defined.
module fifo_rd_cntrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic [ADDR_WIDTH:0]   RQ2_WPTR,
    input  logic [DATA_WIDTH-1:0] MEM_R_DATA,
    input  logic                  RD_READY,
    output logic [ADDR_WIDTH-1:0] R_ADDR,
    output logic [ADDR_WIDTH:0]   GRAY_RD_PTR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  EMPTY
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   LEVEL
`endif
);

    logic [ADDR_WIDTH:0]   rbin_q, rbin_d;
    logic [ADDR_WIDTH:0]   gray_q, gray_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  fetch;

    assign EMPTY = (gray_q == RQ2_WPTR);
    // Refill the output stage whenever it is free or being consumed this cycle.
    assign fetch = !EMPTY && (!rd_valid_q || RD_READY);

    always_comb begin
        rbin_d     = rbin_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (fetch) begin
            rbin_d     = rbin_q + 1'b1;
            rd_data_d  = MEM_R_DATA;
            rd_valid_d = 1'b1;
        end else if (rd_valid_q && RD_READY) begin
            rd_valid_d = 1'b0;
        end
        gray_d = (rbin_d >> 1) ^ rbin_d;
    end

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            rbin_q     <= '0;
            gray_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rbin_q     <= rbin_d;
            gray_q     <= gray_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign R_ADDR      = rbin_q[ADDR_WIDTH-1:0];
    assign GRAY_RD_PTR = gray_q;
    assign RD_DATA     = rd_data_q;
    assign RD_VALID    = rd_valid_q;

`ifdef FIFO_RD_LEVEL_EN
    logic [ADDR_WIDTH:0] wbin;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= int'(ADDR_WIDTH); i++) begin
            wbin[i] = ^(RQ2_WPTR >> i);
        end
    end

    assign LEVEL = (wbin - rbin_q) + {{ADDR_WIDTH{1'b0}}, rd_valid_q};
`endif

endmodule

// File: tb/tb_fifo_rd_cntrl.sv
// Scoreboard bench for fifo_rd_cntrl: directed stimulus pushes expected words, a monitor pops them.
module tb_fifo_rd_cntrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          R_CLK = 1'b0;
    logic          R_RST;
    logic [AW:0]   wbin;
    logic [AW:0]   RQ2_WPTR;
    logic [DW-1:0] mem [8];
    logic [DW-1:0] MEM_R_DATA;
    logic          RD_READY;
    logic [AW-1:0] R_ADDR;
    logic [AW:0]   GRAY_RD_PTR;
    logic [DW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          EMPTY;
`ifdef FIFO_RD_LEVEL_EN
    logic [AW:0]   LEVEL;
`endif

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q [$];

    assign RQ2_WPTR   = wbin ^ (wbin >> 1);
    assign MEM_R_DATA = mem[R_ADDR];

    always #5 R_CLK = ~R_CLK;

    fifo_rd_cntrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .R_CLK       (R_CLK),
        .R_RST       (R_RST),
        .RQ2_WPTR    (RQ2_WPTR),
        .MEM_R_DATA  (MEM_R_DATA),
        .RD_READY    (RD_READY),
        .R_ADDR      (R_ADDR),
        .GRAY_RD_PTR (GRAY_RD_PTR),
        .RD_DATA     (RD_DATA),
        .RD_VALID    (RD_VALID),
        .EMPTY       (EMPTY)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .LEVEL       (LEVEL)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge R_CLK);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"},  32'(R_ADDR), 32'h0);
        check({tag, "_gray"},  32'(GRAY_RD_PTR), 32'h0);
        check({tag, "_valid"}, 32'(RD_VALID), 32'h0);
        check({tag, "_data"},  32'(RD_DATA), 32'h00);
        check({tag, "_empty"}, 32'(EMPTY), 32'h1);
    endtask

    task automatic do_reset();
        R_RST    = 1'b0;
        wbin     = '0;
        RD_READY = 1'b0;
        #1;
        exp_q.delete();
        R_RST = 1'b1;
    endtask

    // A word is consumed at the next rising edge when valid and ready are both high.
    always @(negedge R_CLK) begin
        if (R_RST && RD_VALID && RD_READY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop: unexpected word %0h, expected none", RD_DATA);
            end else begin
                check("pop_data", 32'(RD_DATA), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        R_RST    = 1'b0;
        wbin     = '0;
        RD_READY = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        #12;
        check_reset_vals("rst");

        // Hold: one word fetched, then frozen while not accepted
        mem[0] = 8'hA5;
        wbin   = 4'd1;
        R_RST  = 1'b1;
        tick(1);
        check("hold_valid", 32'(RD_VALID), 32'h1);
        check("hold_data",  32'(RD_DATA), 32'hA5);
        check("hold_addr",  32'(R_ADDR), 32'h1);
        check("hold_gray",  32'(GRAY_RD_PTR), 32'h1);
        check("hold_empty", 32'(EMPTY), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("hold_valid_n", 32'(RD_VALID), 32'h1);
            check("hold_data_n",  32'(RD_DATA), 32'hA5);
            check("hold_addr_n",  32'(R_ADDR), 32'h1);
        end
        exp_q.push_back(8'hA5);
        RD_READY = 1'b1;
        tick(1);
        check("hold_drain_valid", 32'(RD_VALID), 32'h0);
        check("hold_drain_q", 32'(exp_q.size()), 32'h0);

        // Stream four words at full rate
        do_reset();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        wbin     = 4'd4;
        RD_READY = 1'b1;
        tick(4);
        check("stream_last", 32'(RD_DATA), 32'h44);
        check("stream_addr", 32'(R_ADDR), 32'h4);
        tick(1);
        check("stream_valid_end", 32'(RD_VALID), 32'h0);
        tick(2);
        check("stream_idle_valid", 32'(RD_VALID), 32'h0);
        check("stream_idle_addr",  32'(R_ADDR), 32'h4);
        check("stream_q", 32'(exp_q.size()), 32'h0);

        // Reset asserted between edges mid-stream
        do_reset();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        wbin     = 4'd4;
        RD_READY = 1'b1;
        tick(2);
        R_RST = 1'b0;
        wbin  = '0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        R_RST = 1'b1;
        tick(1);
        check("midrst_after_valid", 32'(RD_VALID), 32'h0);

        // Wrap: two full passes through memory
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mem[i] = 8'h80 + 8'(i);
            exp_q.push_back(8'h80 + 8'(i));
        end
        wbin     = 4'd8;
        RD_READY = 1'b1;
        tick(8);
        check("wrap8_gray",  32'(GRAY_RD_PTR), 32'hC);
        check("wrap8_data",  32'(RD_DATA), 32'h87);
        check("wrap8_valid", 32'(RD_VALID), 32'h1);
        for (int i = 0; i < 8; i++) begin
            mem[i] = 8'h90 + 8'(i);
            exp_q.push_back(8'h90 + 8'(i));
        end
        wbin = 4'd0;
        tick(8);
        check("wrap16_gray", 32'(GRAY_RD_PTR), 32'h0);
        check("wrap16_addr", 32'(R_ADDR), 32'h0);
        check("wrap16_data", 32'(RD_DATA), 32'h97);
        tick(1);
        check("wrap_valid_end", 32'(RD_VALID), 32'h0);
        check("wrap_q", 32'(exp_q.size()), 32'h0);

        // Pop and refill to reach RBIN=2 with a held word; write pointer Gray 0111
        do_reset();
        mem[0] = 8'hC1; mem[1] = 8'hC2;
        wbin   = 4'd5;
        tick(1);
        exp_q.push_back(8'hC1);
        RD_READY = 1'b1;
        tick(1);
        RD_READY = 1'b0;
        check("lvl_addr",  32'(R_ADDR), 32'h2);
        check("lvl_valid", 32'(RD_VALID), 32'h1);
        check("lvl_data",  32'(RD_DATA), 32'hC2);
`ifdef FIFO_RD_LEVEL_EN
        check("lvl_level", 32'(LEVEL), 32'h4);
`endif
        check("lvl_q", 32'(exp_q.size()), 32'h0);
        do_reset();
        #1;
        check_reset_vals("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
